// File: rtl/mem_fetch_arbiter_if.sv
// rtl/mem_fetch_arbiter_if.sv - request/response and SPI engine signals of mem_fetch_arbiter
//
// Groups the fetch port, load port, shared response word, buffer invalidate
// and the level-held start/done handshake of the SPI read engine.
//   slave  : arbiter side (takes requests, drives acks and the engine start)
//   master : core / engine side
interface mem_fetch_arbiter_if;
    logic        if_req;
    logic [23:0] if_addr;
    logic        if_ack;
    logic        ld_req;
    logic [23:0] ld_addr;
    logic        ld_ack;
    logic [31:0] rsp_data;
    logic        ibuf_inv;
    logic        mem_start;
    logic [23:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_done;

    modport slave (
        input  if_req, if_addr, ld_req, ld_addr, ibuf_inv, mem_data, mem_done,
        output if_ack, ld_ack, rsp_data, mem_start, mem_addr
    );

    modport master (
        output if_req, if_addr, ld_req, ld_addr, ibuf_inv, mem_data, mem_done,
        input  if_ack, ld_ack, rsp_data, mem_start, mem_addr
    );
endinterface

// File: rtl/mem_fetch_arbiter.sv
// rtl/mem_fetch_arbiter.sv - shares one SPI flash read engine between fetch and load
//
// Arbitrates instruction fetch and data load requests onto the SPI read
// engine: loads win, except that after MAX_LD_STREAK back-to-back load grants
// with a fetch waiting the fetch is served. A one-entry instruction buffer
// answers a repeated fetch of the last fetched word in one cycle.
// Ports:
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   bus   : mem_fetch_arbiter_if.slave (if_*, ld_*, rsp_data, ibuf_inv, mem_*)
// All outputs are registered.
module mem_fetch_arbiter #(
    parameter int unsigned MAX_LD_STREAK = 4,
    parameter bit          IBUF_EN       = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    mem_fetch_arbiter_if.slave         bus
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BUSY    = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    localparam logic OWN_LD = 1'b0;
    localparam logic OWN_IF = 1'b1;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_LD_STREAK);

    logic [1:0]  state_q, state_d;
    logic [3:0]  streak_q, streak_d;
    logic        owner_q, owner_d;
    logic        mem_start_q, mem_start_d;
    logic [23:0] mem_addr_q, mem_addr_d;
    logic        if_ack_q, if_ack_d;
    logic        ld_ack_q, ld_ack_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        buf_valid_q, buf_valid_d;
    logic [23:0] buf_addr_q, buf_addr_d;
    logic [31:0] buf_data_q, buf_data_d;

    logic grant_if;
    logic ibuf_hit;
    logic owner_req;

    // The fetch wins only when no load is waiting or the load streak is used up.
    assign grant_if  = bus.if_req && (!bus.ld_req || (streak_q == STREAK_MAX));
    // An invalidate in the same cycle must not let a stale word through.
    assign ibuf_hit  = IBUF_EN && buf_valid_q && !bus.ibuf_inv
                       && (bus.if_addr == buf_addr_q);
    assign owner_req = (owner_q == OWN_IF) ? bus.if_req : bus.ld_req;

    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        owner_d     = owner_q;
        mem_start_d = mem_start_q;
        mem_addr_d  = mem_addr_q;
        if_ack_d    = 1'b0;
        ld_ack_d    = 1'b0;
        rsp_data_d  = rsp_data_q;
        buf_valid_d = buf_valid_q;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_if) begin
                    streak_d = '0;
                    if (ibuf_hit) begin
                        rsp_data_d = buf_data_q;
                        if_ack_d   = 1'b1;
                        state_d    = ST_RELEASE;
                    end else begin
                        mem_addr_d  = bus.if_addr;
                        mem_start_d = 1'b1;
                        owner_d     = OWN_IF;
                        state_d     = ST_BUSY;
                    end
                end else if (bus.ld_req) begin
                    // Only loads that overtake a waiting fetch count towards the streak.
                    if (bus.if_req) begin
                        streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + 4'd1;
                    end else begin
                        streak_d = '0;
                    end
                    mem_addr_d  = bus.ld_addr;
                    mem_start_d = 1'b1;
                    owner_d     = OWN_LD;
                    state_d     = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!owner_req) begin
                    // Requester gave up: drop start to abort the engine, no ack.
                    mem_start_d = 1'b0;
                    state_d     = ST_RELEASE;
                end else if (bus.mem_done) begin
                    rsp_data_d  = bus.mem_data;
                    mem_start_d = 1'b0;
                    state_d     = ST_RELEASE;
                    if (owner_q == OWN_IF) begin
                        if_ack_d    = 1'b1;
                        buf_addr_d  = mem_addr_q;
                        buf_data_d  = bus.mem_data;
                        buf_valid_d = 1'b1;
                    end else begin
                        ld_ack_d = 1'b1;
                    end
                end
            end
            ST_RELEASE: begin
                // One cycle with start low so the engine returns to its start state.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Invalidate overrides a fill landing in the same cycle.
        if (bus.ibuf_inv) begin
            buf_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            streak_q    <= '0;
            owner_q     <= OWN_LD;
            mem_start_q <= 1'b0;
            mem_addr_q  <= '0;
            if_ack_q    <= 1'b0;
            ld_ack_q    <= 1'b0;
            rsp_data_q  <= '0;
            buf_valid_q <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            owner_q     <= owner_d;
            mem_start_q <= mem_start_d;
            mem_addr_q  <= mem_addr_d;
            if_ack_q    <= if_ack_d;
            ld_ack_q    <= ld_ack_d;
            rsp_data_q  <= rsp_data_d;
            buf_valid_q <= buf_valid_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
        end
    end

    assign bus.mem_start = mem_start_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.ld_ack    = ld_ack_q;
    assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_mem_fetch_arbiter.sv
// tb/tb_mem_fetch_arbiter.sv - self-checking bench for mem_fetch_arbiter
module tb_mem_fetch_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_fetch_arbiter_if b ();

    mem_fetch_arbiter #(
        .MAX_LD_STREAK (4),
        .IBUF_EN       (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b)
    );

    int total = 0;
    int bad   = 0;

    // SPI engine model: done after eng_lat cycles of start, data from a fixed map.
    logic        eng_done = 1'b0;
    logic [31:0] eng_data = 32'h0;
    int          eng_lat = 2;
    int          eng_cnt = 0;
    logic        start_prev = 1'b0;
    int          spi_cnt = 0;
    logic [23:0] last_addr = 24'h0;
    int          ld_ack_cnt = 0;
    int          both_ack_cnt = 0;

    assign b.mem_done = eng_done;
    assign b.mem_data = eng_data;

    function automatic logic [31:0] eng_word(input logic [23:0] a);
        case (a)
            24'h000100: eng_word = 32'hDEADBEEF;
            24'h000040: eng_word = 32'h12345678;
            default:    eng_word = {8'hC3, a};
        endcase
    endfunction

    always @(posedge clk) begin
        #2;
        if (b.mem_start) begin
            if (!start_prev) begin
                spi_cnt   = spi_cnt + 1;
                last_addr = b.mem_addr;
                eng_cnt   = 0;
            end
            eng_cnt = eng_cnt + 1;
            if (eng_cnt >= eng_lat) begin
                eng_done = 1'b1;
                eng_data = eng_word(b.mem_addr);
            end
        end else begin
            eng_cnt  = 0;
            eng_done = 1'b0;
            eng_data = 32'h0;
        end
        start_prev = b.mem_start;
    end

    always @(negedge clk) begin
        if (b.ld_ack) ld_ack_cnt = ld_ack_cnt + 1;
        if (b.ld_ack && b.if_ack) both_ack_cnt = both_ack_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic wait_ack(output logic got_if, output int n);
        logic seen;
        seen = 1'b0;
        got_if = 1'b0;
        n = 0;
        while (!seen && n < 400) begin
            @(negedge clk);
            n++;
            if (b.if_ack || b.ld_ack) begin
                seen = 1'b1;
                got_if = b.if_ack;
            end
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL ack_timeout actual=none required=ack within 400 cycles");
        end
    endtask

    // One request on one port, checked for port, data, latency, SPI use and hold.
    task automatic run_txn(input logic is_if, input logic [23:0] addr, input int lat,
                           input logic exp_spi, input logic [31:0] exp_data, input int exp_n);
        int   spi0;
        int   n;
        logic got_if;
        eng_lat = lat;
        spi0 = spi_cnt;
        if (is_if) begin
            b.if_addr = addr;
            b.if_req  = 1'b1;
        end else begin
            b.ld_addr = addr;
            b.ld_req  = 1'b1;
        end
        wait_ack(got_if, n);
        if (is_if) b.if_req = 1'b0;
        else       b.ld_req = 1'b0;
        chk("ack_port", {31'h0, got_if}, {31'h0, is_if});
        chk("rsp_data", b.rsp_data, exp_data);
        chk("latency", 32'(n), 32'(exp_n));
        chk("spi_used", 32'(spi_cnt - spi0), {31'h0, exp_spi});
        if (exp_spi) chk("mem_addr", {8'h0, last_addr}, {8'h0, addr});
        chk("start_low_at_ack", {31'h0, b.mem_start}, 32'h0);
        @(negedge clk);
        chk("rsp_hold", b.rsp_data, exp_data);
        chk("ack_cleared", {30'h0, b.if_ack, b.ld_ack}, 32'h0);
    endtask

    typedef struct {
        logic        is_if;
        logic [23:0] addr;
        int          lat;
        logic        spi;
        logic [31:0] data;
        int          n;
    } vec_t;

    vec_t vecs [8];
    logic gi;
    int   n;
    int   spi0;
    int   ld0;

    initial begin
        vecs[0] = '{1'b0, 24'h000100, 70, 1'b1, 32'hDEADBEEF, 71};
        vecs[1] = '{1'b1, 24'h000040,  5, 1'b1, 32'h12345678,  6};
        vecs[2] = '{1'b1, 24'h000040,  5, 1'b0, 32'h12345678,  1};
        vecs[3] = '{1'b0, 24'h000040,  3, 1'b1, 32'h12345678,  4};
        vecs[4] = '{1'b1, 24'h000080,  2, 1'b1, 32'hC3000080,  3};
        vecs[5] = '{1'b1, 24'h000040,  4, 1'b1, 32'h12345678,  5};
        vecs[6] = '{1'b1, 24'h000040,  4, 1'b0, 32'h12345678,  1};
        vecs[7] = '{1'b0, 24'h000200,  1, 1'b1, 32'hC3000200,  2};

        b.if_req   = 1'b0;
        b.if_addr  = 24'h0;
        b.ld_req   = 1'b0;
        b.ld_addr  = 24'h0;
        b.ibuf_inv = 1'b0;
        rst_n      = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mem_start", {31'h0, b.mem_start}, 32'h0);
        chk("rst_mem_addr", {8'h0, b.mem_addr}, 32'h0);
        chk("rst_acks", {30'h0, b.if_ack, b.ld_ack}, 32'h0);
        chk("rst_rsp_data", b.rsp_data, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i].is_if, vecs[i].addr, vecs[i].lat, vecs[i].spi, vecs[i].data, vecs[i].n);
        end

        // Invalidate while idle: next fetch of the buffered word goes to SPI.
        b.ibuf_inv = 1'b1;
        @(negedge clk);
        b.ibuf_inv = 1'b0;
        run_txn(1'b1, 24'h000040, 2, 1'b1, 32'h12345678, 3);

        // Invalidate in the same cycle as the hit decision suppresses the hit.
        b.ibuf_inv = 1'b1;
        fork
            begin
                @(negedge clk);
                b.ibuf_inv = 1'b0;
            end
        join_none
        run_txn(1'b1, 24'h000040, 2, 1'b1, 32'h12345678, 3);
        run_txn(1'b1, 24'h000040, 0, 1'b0, 32'h12345678, 1);

        // Invalidate coincident with the buffer fill discards the fill.
        eng_lat = 2;
        b.if_addr = 24'h000700;
        b.if_req  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        b.ibuf_inv = 1'b1;
        @(negedge clk);
        chk("fill_inv_ack", {31'h0, b.if_ack}, 32'h1);
        chk("fill_inv_data", b.rsp_data, 32'hC3000700);
        b.ibuf_inv = 1'b0;
        b.if_req   = 1'b0;
        @(negedge clk);
        run_txn(1'b1, 24'h000700, 2, 1'b1, 32'hC3000700, 3);

        // Simultaneous requests: load first, then the fetch.
        eng_lat = 2;
        b.ld_addr = 24'h000300;
        b.if_addr = 24'h000400;
        b.ld_req  = 1'b1;
        b.if_req  = 1'b1;
        wait_ack(gi, n);
        b.ld_req = 1'b0;
        chk("simul_first_is_load", {31'h0, gi}, 32'h0);
        chk("simul_first_data", b.rsp_data, 32'hC3000300);
        chk("simul_first_lat", 32'(n), 32'd3);
        wait_ack(gi, n);
        b.if_req = 1'b0;
        chk("simul_second_is_if", {31'h0, gi}, 32'h1);
        chk("simul_second_data", b.rsp_data, 32'hC3000400);
        chk("simul_second_lat", 32'(n), 32'd4);
        chk("simul_second_addr", {8'h0, last_addr}, 32'h000400);
        @(negedge clk);

        // Load streak: exactly four loads, then the waiting fetch.
        b.ld_addr = 24'h000600;
        b.if_addr = 24'h000500;
        b.ld_req  = 1'b1;
        b.if_req  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_ack(gi, n);
            chk($sformatf("streak_grant%0d_is_if", k), {31'h0, gi}, (k == 4) ? 32'h1 : 32'h0);
        end
        b.if_req = 1'b0;
        chk("streak_if_data", b.rsp_data, 32'hC3000500);
        wait_ack(gi, n);
        b.ld_req = 1'b0;
        chk("streak_tail_is_load", {31'h0, gi}, 32'h0);
        @(negedge clk);

        // Abort: load dropped 10 cycles into BUSY, pending fetch then hits.
        eng_lat = 1000;
        ld0  = ld_ack_cnt;
        spi0 = spi_cnt;
        b.ld_addr = 24'h000600;
        b.if_addr = 24'h000500;
        b.ld_req  = 1'b1;
        b.if_req  = 1'b1;
        @(negedge clk);
        chk("abort_start_high", {31'h0, b.mem_start}, 32'h1);
        chk("abort_mem_addr", {8'h0, b.mem_addr}, 32'h000600);
        repeat (9) @(negedge clk);
        b.ld_req = 1'b0;
        @(negedge clk);
        chk("abort_start_low", {31'h0, b.mem_start}, 32'h0);
        wait_ack(gi, n);
        b.if_req = 1'b0;
        chk("abort_then_if", {31'h0, gi}, 32'h1);
        chk("abort_if_lat", 32'(n), 32'd2);
        chk("abort_if_hit_data", b.rsp_data, 32'hC3000500);
        chk("abort_no_ld_ack", 32'(ld_ack_cnt - ld0), 32'h0);
        chk("abort_spi_count", 32'(spi_cnt - spi0), 32'h1);
        @(negedge clk);

        // Reset mid-transaction clears outputs and the buffer.
        run_txn(1'b1, 24'h000800, 2, 1'b1, 32'hC3000800, 3);
        run_txn(1'b1, 24'h000800, 0, 1'b0, 32'hC3000800, 1);
        eng_lat = 1000;
        b.if_addr = 24'h000900;
        b.if_req  = 1'b1;
        repeat (3) @(negedge clk);
        rst_n    = 1'b0;
        b.if_req = 1'b0;
        @(negedge clk);
        chk("midrst_mem_start", {31'h0, b.mem_start}, 32'h0);
        chk("midrst_mem_addr", {8'h0, b.mem_addr}, 32'h0);
        chk("midrst_acks", {30'h0, b.if_ack, b.ld_ack}, 32'h0);
        chk("midrst_rsp_data", b.rsp_data, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        run_txn(1'b1, 24'h000800, 2, 1'b1, 32'hC3000800, 3);

        chk("ack_exclusive", 32'(both_ack_cnt), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_fetch_arbiter.md
# mem_fetch_arbiter

Shares the single SPI flash read engine between the instruction-fetch and data-load requesters of the RV32E core. It sequences the engine's level-held start/done handshake, arbitrates with load priority plus an instruction anti-starvation guard, and returns read data to the winning requester. A one-entry instruction buffer answers repeated fetches of the same word without an SPI transaction. It sits between the core's fetch/LSU stages and the SPI read engine.

## Interface
- MAX_LD_STREAK, 4: consecutive load grants allowed while if_req is pending; range 1..15.
- IBUF_EN, 1: 1 enables the one-entry instruction buffer; 0 sends every fetch to SPI.
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- if_req  in  1  instruction fetch request, level; held until if_ack.
- if_addr  in  24  fetch byte address; stable while if_req=1.
- if_ack  out  1  one-cycle pulse; rsp_data is valid for the fetch in this cycle.
- ld_req  in  1  data load request, level; held until ld_ack.
- ld_addr  in  24  load byte address; stable while ld_req=1.
- ld_ack  out  1  one-cycle pulse; rsp_data is valid for the load in this cycle.
- rsp_data  out  32  response word, shared by both ports.
- ibuf_inv  in  1  single-cycle pulse that clears the instruction buffer.
- mem_start  out  1  engine start; held high for the whole transaction.
- mem_addr  out  24  engine target address; registered at grant.
- mem_data  in  32  engine read data; valid when mem_done=1.
- mem_done  in  1  engine completion; stays high while mem_start=1.

## Operation
- States: IDLE, BUSY, RELEASE.
- IDLE, grant selection, first match wins:
  1. If ld_req=1, if_req=1, and streak==MAX_LD_STREAK, grant instruction.
  2. Else if ld_req=1, grant load.
  3. Else if if_req=1, grant instruction.
- Streak counter:
  - Increments on each load grant made while if_req=1.
  - Clears on any instruction grant.
  - Clears on a load grant made while if_req=0.
  - Saturates at MAX_LD_STREAK.
- Instruction grant that hits the buffer (IBUF_EN=1, buf_valid=1, if_addr==buf_addr):
  - Next edge: rsp_data<=buf_data, if_ack<=1, state RELEASE.
  - mem_start stays 0.
- Any other grant:
  - Next edge: mem_addr<=address, mem_start<=1, owner<=port, state BUSY.
- BUSY, mem_done=1 and owner still requesting:
  - rsp_data<=mem_data, owner's ack<=1, mem_start<=0, state RELEASE.
  - If owner is the instruction port: buf_addr<=mem_addr, buf_data<=mem_data, buf_valid<=1.
- BUSY, owner drops its req before mem_done (abort):
  - mem_start<=0, state RELEASE.
  - No ack; the buffer is not updated.
- RELEASE: ack returns to 0; state IDLE next edge.
  - Guarantees mem_start low for at least one cycle between transactions, which the engine requires to return to its start state.
- Requester rule: req must be low in the cycle after its ack. A req still high then is treated as a new request.
- ibuf_inv clears buf_valid at the next edge.
  - It takes priority over a simultaneous buffer fill, so the fill is discarded.
  - A hit decision in the same IDLE cycle as ibuf_inv=1 is suppressed and the fetch goes to SPI.
- Reset, including mid-transaction: state IDLE, mem_start 0, mem_addr 0, if_ack 0, ld_ack 0, rsp_data 0, buf_valid 0, streak 0. The engine is aborted by mem_start falling.

## Timing
- All outputs are registered; none depends combinationally on inputs.
- SPI path: req high in cycle N (state IDLE) → mem_start=1 in cycle N+1.
- Ack timing: mem_done first sampled high at edge E → ack and rsp_data valid in the cycle after E; mem_start=0 in that same cycle.
- Buffer hit: req in cycle N → ack in cycle N+1 → IDLE in cycle N+2.
- Minimum spacing: two consecutive SPI transactions are at least 2 cycles apart from ack to the next mem_start.
- rsp_data holds its value until the next ack.
- if_ack and ld_ack are never high in the same cycle.

## Test plan
- Single load: ld_req, ld_addr=0x000100, engine returns 0xDEADBEEF after 70 cycles → mem_addr=0x000100, one ld_ack pulse with rsp_data=0xDEADBEEF, mem_start low for ≥1 cycle afterwards.
- Buffer hit: fetch 0x000040 via SPI (returns 0x12345678), then fetch 0x000040 again → second if_ack 1 cycle after req, mem_start stays 0. Pulse ibuf_inv, fetch again → goes to SPI.
- Simultaneous requests: if_req and ld_req high together → load served first, then instruction. With ld_req held continuously and MAX_LD_STREAK=4 → an instruction grant occurs after exactly 4 load grants.
- Abort: ld_req dropped 10 cycles into BUSY → mem_start falls next edge, no ld_ack, buffer unchanged, a pending if_req is granted after RELEASE.
- Reset mid-transaction: rst_n low for 1 cycle during BUSY → all outputs 0 next edge, buf_valid 0; a following fetch of a previously buffered address goes to SPI.
